ddr3_iod_dly_ctrl: RTL
======================

DDR3_IOD_DLY_CTRL -- requirements
Module: ddr3_iod_dly_ctrl

Interface
REQ-001 The module SHALL have parameter MAX_TAPS, default 127, highest legal tap value.
REQ-002 The module SHALL have parameter LOAD_TAP, default 1, tap value restored by LOAD and by reset; it matches the IOD TX_DELAY_VAL.
REQ-003 The module SHALL have parameter MOVE_GAP, default 3, range 1-15, idle cycles between consecutive DELAY_LINE_MOVE pulses.
REQ-004 The module SHALL use one clock and a synchronous, active-low reset, with ports in this order:
- FAB_CLK  in  1  sole clock; all logic on rising edge.
- SYNC_RST_N  in  1  synchronous active-low reset.
- REQ_VALID  in  1  command valid.
- REQ_READY  out  1  command accepted when high together with REQ_VALID.
- REQ_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 reserved.
- REQ_COUNT  in  7  number of taps for INC/DEC; ignored for LOAD.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  valid only with DONE; 1 = command aborted or illegal.
- TAP_VAL  out  7  current tap estimate.
- DELAY_LINE_MOVE  out  1  to IOD; one-cycle step pulse.
- DELAY_LINE_DIRECTION  out  1  to IOD; 1 = increment, 0 = decrement.
- DELAY_LINE_LOAD  out  1  to IOD; one-cycle load pulse.
- DELAY_LINE_OUT_OF_RANGE  in  1  from IOD; delay line hit its limit.

Function
REQ-005 The FSM SHALL have states IDLE, LOAD, MOVE, GAP and FIN, and all outputs except REQ_READY SHALL be registered.
REQ-006 REQ_READY SHALL be 1 only in IDLE. A command is accepted on the edge where REQ_VALID and REQ_READY are both 1, and REQ_OP and REQ_COUNT are captured at that edge.
REQ-007 LOAD command: IDLE->LOAD, with DELAY_LINE_LOAD=1 for exactly one cycle; TAP_VAL<=LOAD_TAP at the end of that cycle; then GAP for MOVE_GAP cycles, then FIN with ERR=0.
REQ-008 INC/DEC command: DELAY_LINE_DIRECTION is set at accept and held constant until the next accept.
- Each MOVE state drives DELAY_LINE_MOVE=1 for exactly one cycle and adjusts TAP_VAL by +/-1.
- The remaining count decrements on each MOVE.
REQ-009 After a MOVE, the FSM SHALL go to FIN if the remaining count is 0; otherwise it SHALL go to GAP for MOVE_GAP cycles, then MOVE.
REQ-010 Timing for an accept at edge 0, count N, gap G:
- MOVE pulses in cycles 1+k(G+1), for k=0..N-1.
- DONE in cycle 1+(N-1)(G+1)+1.
REQ-011 INC/DEC with REQ_COUNT=0 SHALL go IDLE->FIN with no MOVE pulse and ERR=0.
REQ-012 REQ_OP=11 SHALL go IDLE->FIN with no IOD pulse, ERR=1, and TAP_VAL unchanged.
REQ-013 Saturation is checked before each MOVE. If INC and TAP_VAL==MAX_TAPS, or DEC and TAP_VAL==0, the FSM SHALL skip the pulse and go to FIN with ERR=1; TAP_VAL never wraps.
REQ-014 DELAY_LINE_OUT_OF_RANGE sampled high in any GAP cycle of an INC/DEC command SHALL abort to FIN on the next edge with ERR=1. Remaining moves are dropped. TAP_VAL keeps the moves already issued.
REQ-015 DELAY_LINE_OUT_OF_RANGE SHALL be ignored in IDLE, LOAD and FIN, and during the GAP of a LOAD command.
REQ-016 FIN SHALL last one cycle with DONE=1, then return to IDLE. REQ_READY=1 resumes in the cycle after DONE.
REQ-017 DELAY_LINE_MOVE and DELAY_LINE_LOAD SHALL never be high in the same cycle. No IOD pulse occurs in IDLE, GAP or FIN.

Reset
REQ-018 While SYNC_RST_N=0 at an edge, the block SHALL set state=IDLE, TAP_VAL=LOAD_TAP, and clear remaining count and gap counter to 0.
REQ-019 Reset values: DONE=0, ERR=0, DELAY_LINE_MOVE=0, DELAY_LINE_LOAD=0, DELAY_LINE_DIRECTION=1.
REQ-020 REQ_READY=1 in the first cycle after SYNC_RST_N rises.
REQ-021 Reset asserted mid-command SHALL abandon the command with no DONE pulse. Any IOD pulse already high drops at the reset edge.

Verification
REQ-022 Reset, then INC count 3, MOVE_GAP=3 -> MOVE high in cycles 1, 5, 9 with DIRECTION=1; DONE=1, ERR=0 in cycle 10; TAP_VAL=4.
REQ-023 From TAP_VAL=4: DEC count 6 -> four MOVE pulses with DIRECTION=0, TAP_VAL=0, then DONE with ERR=1 and no fifth pulse.
REQ-024 INC count 10 with DELAY_LINE_OUT_OF_RANGE forced high in the first GAP cycle -> exactly one MOVE, DONE with ERR=1, TAP_VAL=LOAD_TAP+1.
REQ-025 LOAD after TAP_VAL=50 -> one DELAY_LINE_LOAD pulse in cycle 1, TAP_VAL=1, DONE in cycle 5 (MOVE_GAP=3), ERR=0.
REQ-026 Edge cases:
- REQ_OP=11 -> DONE with ERR=1 in cycle 1, no IOD pulse.
- REQ_COUNT=0 INC -> DONE with ERR=0 in cycle 1.
- REQ_VALID held high back-to-back -> the next accept occurs only in the cycle after DONE.
REQ-027 SYNC_RST_N low for one cycle during the second GAP of INC count 5 -> no DONE; TAP_VAL=LOAD_TAP; REQ_READY=1 in the next cycle; no further MOVE pulses.

Source files
------------

// File: rtl/ddr3_iod_dly_ctrl_if.sv
// ddr3_iod_dly_ctrl_if: command handshake, status and IOD delay-line signals for the tap controller
interface ddr3_iod_dly_ctrl_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [1:0] REQ_OP;
  logic [6:0] REQ_COUNT;
  logic       DONE;
  logic       ERR;
  logic [6:0] TAP_VAL;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_OUT_OF_RANGE;
  modport master (
    output REQ_VALID, REQ_OP, REQ_COUNT, DELAY_LINE_OUT_OF_RANGE,
    input  REQ_READY, DONE, ERR, TAP_VAL, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD
  );
  modport slave (
    input  REQ_VALID, REQ_OP, REQ_COUNT, DELAY_LINE_OUT_OF_RANGE,
    output REQ_READY, DONE, ERR, TAP_VAL, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD
  );
endinterface

// File: rtl/ddr3_iod_dly_ctrl.sv
// ddr3_iod_dly_ctrl: steps, loads and tracks an IOD delay-line tap with saturation and out-of-range abort
module ddr3_iod_dly_ctrl #(
  parameter int MAX_TAPS = 127,
  parameter int LOAD_TAP = 1,
  parameter int MOVE_GAP = 3
) (
  input logic FAB_CLK,
  input logic SYNC_RST_N,
  ddr3_iod_dly_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, MOVE, GAP, FIN} state_t;
  localparam logic [6:0] MAX_T = 7'(MAX_TAPS);
  localparam logic [6:0] LOAD_T = 7'(LOAD_TAP);
  localparam logic [3:0] GAP_INIT = 4'(MOVE_GAP - 1);
  state_t r_state, w_nxt;
  logic [6:0] r_tap, r_cnt;
  logic [3:0] r_gap;
  logic [1:0] r_op;
  logic r_dir, r_done, r_err, r_move, r_load;
  logic w_acc, w_inc, w_sat, w_err;
  assign w_acc = bus.REQ_VALID && r_state == IDLE;
  // at accept the direction register is not yet written, so take it from the request
  assign w_inc = (r_state == IDLE) ? bus.REQ_OP == 2'b01 : r_dir;
  assign w_sat = w_inc ? r_tap == MAX_T : r_tap == 7'd0;
  always_comb begin
    w_nxt = r_state;
    w_err = 1'b0;
    case (r_state)
      IDLE: if (bus.REQ_VALID) begin
        if (bus.REQ_OP == 2'b00) w_nxt = LOAD;
        else if (bus.REQ_OP == 2'b11) begin w_nxt = FIN; w_err = 1'b1; end
        else if (bus.REQ_COUNT == 7'd0) w_nxt = FIN;
        else if (w_sat) begin w_nxt = FIN; w_err = 1'b1; end
        else w_nxt = MOVE;
      end
      LOAD: w_nxt = GAP;
      MOVE: w_nxt = (r_cnt == 7'd1) ? FIN : GAP;
      GAP: if (r_op != 2'b00 && bus.DELAY_LINE_OUT_OF_RANGE) begin w_nxt = FIN; w_err = 1'b1; end
        else if (r_gap == 4'd0) begin
          if (r_op == 2'b00) w_nxt = FIN;
          else if (w_sat) begin w_nxt = FIN; w_err = 1'b1; end
          else w_nxt = MOVE;
        end
      FIN: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge FAB_CLK) begin
    if (!SYNC_RST_N) begin
      r_state <= IDLE;
      r_tap <= LOAD_T;
      r_cnt <= 7'd0;
      r_gap <= 4'd0;
      r_op <= 2'b00;
      r_dir <= 1'b1;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_move <= 1'b0;
      r_load <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_done <= w_nxt == FIN;
      r_err <= w_err;
      r_move <= w_nxt == MOVE;
      r_load <= w_nxt == LOAD;
      r_gap <= (r_state == GAP && r_gap != 4'd0) ? r_gap - 4'd1 : GAP_INIT;
      if (w_acc) begin
        r_op <= bus.REQ_OP;
        r_cnt <= bus.REQ_COUNT;
        if (^bus.REQ_OP) r_dir <= bus.REQ_OP[0];
      end
      if (r_state == MOVE) begin
        r_cnt <= r_cnt - 7'd1;
        r_tap <= r_dir ? r_tap + 7'd1 : r_tap - 7'd1;
      end
      if (r_state == LOAD) r_tap <= LOAD_T;
    end
  end
  assign bus.REQ_READY = r_state == IDLE;
  assign bus.DONE = r_done;
  assign bus.ERR = r_err;
  assign bus.TAP_VAL = r_tap;
  assign bus.DELAY_LINE_MOVE = r_move;
  assign bus.DELAY_LINE_DIRECTION = r_dir;
  assign bus.DELAY_LINE_LOAD = r_load;
endmodule
